// File: rtl/pov_frame_mapper_if.sv
// Pixel request / texture ROM / pixel response bus of the POV frame mapper.
interface pov_frame_mapper_if #(
  parameter int PX_BITS    = 6,
  parameter int THETA_BITS = 6,
  parameter int ADDR_BITS  = 17
);
  logic                  px_req;
  logic [PX_BITS-1:0]    px_num;
  logic [THETA_BITS-1:0] theta;
  logic [THETA_BITS-1:0] col_offset;
  logic [ADDR_BITS-1:0]  rom_addr;
  logic [23:0]           rom_data;
  logic [23:0]           pixel_out;
  logic                  pixel_valid;

  modport slave (
    input  px_req, px_num, theta, col_offset, rom_data,
    output rom_addr, pixel_out, pixel_valid
  );

  modport master (
    output px_req, px_num, theta, col_offset, rom_data,
    input  rom_addr, pixel_out, pixel_valid
  );
endinterface

// File: rtl/pov_frame_mapper.sv
// Animated POV texture mapper: frame timer/sequencer plus a 3-stage
// request -> ROM address -> adjusted GRB pixel pipeline.
module pov_frame_mapper #(
  parameter int LED_COUNT        = 52,
  parameter int PX_BITS          = 6,
  parameter int THETA_BITS       = 6,
  parameter int NUM_FRAMES       = 30,
  parameter int CYCLES_PER_FRAME = 6666667,
  parameter int ADDR_BITS        = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       pause,
  input  logic       step,
  input  logic [1:0] brightness,
  input  logic       invert,
  output logic [7:0] frame_idx,
  output logic       frame_tick,
  pov_frame_mapper_if.slave bus
);
  localparam int TEX_WIDTH = 1 << THETA_BITS;
  localparam int CNT_W     = $clog2(CYCLES_PER_FRAME);
  localparam int STAGES    = 2;

  localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(CYCLES_PER_FRAME - 1);
  localparam logic [7:0]           LAST_IDX  = 8'(NUM_FRAMES - 1);
  localparam logic [ADDR_BITS-1:0] FRAME_SZ  = ADDR_BITS'(TEX_WIDTH * LED_COUNT);
  localparam logic [ADDR_BITS-1:0] LAST_BASE = ADDR_BITS'((NUM_FRAMES - 1) * TEX_WIDTH * LED_COUNT);

  typedef enum logic {DIR_UP, DIR_DN} dir_t;

  logic [CNT_W-1:0]     cnt;
  logic                 adv;
  dir_t                 dir, dir_nxt;
  logic [7:0]           idx_nxt;
  logic [ADDR_BITS-1:0] frame_base, base_nxt;

  // A paused timer only moves on an explicit step; a running one ignores step.
  assign adv = pause ? step : (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
      frame_idx  <= '0;
      frame_base <= '0;
      dir        <= DIR_UP;
    end else begin
      frame_tick <= adv;
      if (adv)        cnt <= '0;
      else if (!pause) cnt <= cnt + 1'b1;
      frame_idx  <= idx_nxt;
      frame_base <= base_nxt;
      dir        <= dir_nxt;
    end
  end

  // Base address tracks frame_idx by +/- one frame size or a constant reload.
  always_comb begin
    idx_nxt  = frame_idx;
    base_nxt = frame_base;
    dir_nxt  = dir;
    if (adv && NUM_FRAMES > 1) begin
      case (mode)
        2'd0: begin
          if (frame_idx == LAST_IDX) begin
            idx_nxt  = '0;
            base_nxt = '0;
          end else begin
            idx_nxt  = frame_idx + 8'd1;
            base_nxt = frame_base + FRAME_SZ;
          end
        end
        2'd1: begin
          if (frame_idx == '0) begin
            idx_nxt  = LAST_IDX;
            base_nxt = LAST_BASE;
          end else begin
            idx_nxt  = frame_idx - 8'd1;
            base_nxt = frame_base - FRAME_SZ;
          end
        end
        2'd2: begin
          if ((dir == DIR_UP && frame_idx != LAST_IDX) ||
              (dir == DIR_DN && frame_idx == '0)) begin
            idx_nxt  = frame_idx + 8'd1;
            base_nxt = frame_base + FRAME_SZ;
          end else begin
            idx_nxt  = frame_idx - 8'd1;
            base_nxt = frame_base - FRAME_SZ;
          end
          if (dir == DIR_UP && frame_idx == LAST_IDX) dir_nxt = DIR_DN;
          if (dir == DIR_DN && frame_idx == '0)       dir_nxt = DIR_UP;
        end
        default: ;
      endcase
    end
  end

  // Pixel pipeline
  logic [THETA_BITS-1:0] col;
  logic                  oob;
  logic [ADDR_BITS-1:0]  addr_calc;
  logic [ADDR_BITS-1:0]  rom_addr_q;
  logic [23:0]           pix_q, pix_adj;
  logic [STAGES:0]       vld_pipe;
  logic [STAGES-1:0]     oob_pipe;
  logic [7:0]            inv_mask;

  assign col       = bus.theta + bus.col_offset;
  assign oob       = {1'b0, bus.px_num} >= (PX_BITS+1)'(LED_COUNT);
  assign addr_calc = frame_base + ADDR_BITS'({bus.px_num, col});
  assign inv_mask  = {8{invert}};
  assign pix_adj   = {(bus.rom_data[23:16] >> brightness) ^ inv_mask,
                      (bus.rom_data[15:8]  >> brightness) ^ inv_mask,
                      (bus.rom_data[7:0]   >> brightness) ^ inv_mask};

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe   <= '0;
      oob_pipe   <= '0;
      rom_addr_q <= '0;
      pix_q      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.px_req};
      oob_pipe <= {oob_pipe[STAGES-2:0], oob};
      if (bus.px_req && !oob) rom_addr_q <= addr_calc;
      // rom_data and the adjust controls are both sampled in the cycle after rom_addr
      if (vld_pipe[STAGES-1]) pix_q <= oob_pipe[STAGES-1] ? 24'h000000 : pix_adj;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.pixel_out   = pix_q;
  assign bus.pixel_valid = vld_pipe[STAGES];
endmodule
